// File: rtl/mips_pkg.sv
// Shared MIPS-32 pipeline definitions: opcodes, EX/MEM instruction types, MEM/WB FSM
// states and the destination-register decode used by the write-back stage.
package mips_pkg;

  localparam int unsigned DefaultMemDepth = 1024;

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAnd   = 6'b000010;
  localparam logic [5:0] OpOr    = 6'b000011;
  localparam logic [5:0] OpSlt   = 6'b000100;
  localparam logic [5:0] OpMul   = 6'b000101;
  localparam logic [5:0] OpLw    = 6'b001000;
  localparam logic [5:0] OpSw    = 6'b001001;
  localparam logic [5:0] OpAddi  = 6'b001010;
  localparam logic [5:0] OpSubi  = 6'b001011;
  localparam logic [5:0] OpSlti  = 6'b001100;
  localparam logic [5:0] OpBneqz = 6'b001101;
  localparam logic [5:0] OpBeqz  = 6'b001110;
  localparam logic [5:0] OpHlt   = 6'b111111;

  typedef enum logic [2:0] {
    TypeRrAlu  = 3'd0,
    TypeRmAlu  = 3'd1,
    TypeLoad   = 3'd2,
    TypeStore  = 3'd3,
    TypeBranch = 3'd4,
    TypeHalt   = 3'd5
  } instr_type_e;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLoadWait = 2'd1,
    StWbLoad   = 2'd2
  } mem_wb_state_e;

  // Zero means "no register write", which also covers writes aimed at R0.
  function automatic logic [4:0] dest_reg(input instr_type_e itype,
                                          input logic [4:0]  rd,
                                          input logic [4:0]  rt);
    case (itype)
      TypeRrAlu:           return rd;
      TypeRmAlu, TypeLoad: return rt;
      default:             return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/mips_data_mem.sv
// Data memory: synchronous write, combinational read port for loads and a separate
// combinational debug read port. Contents are deliberately not reset.
module mips_data_mem
  import mips_pkg::*;
#(
  parameter int unsigned Depth = DefaultMemDepth,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic [Aw-1:0] dbg_addr_i,
  output logic [31:0]   dbg_data_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/mips_mem_wb.sv
// MEM + WB stage: stores/loads against the data memory, registered register-bank write,
// sticky halt flag and a load-latency stall FSM that holds off the execute stage.
module mips_mem_wb
  import mips_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DefaultMemDepth,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_ir,
  input  logic [2:0]  ex_type,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_b,
  input  logic        taken_branch,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        halted,
  input  logic [9:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int unsigned Aw   = $clog2(MEM_DEPTH);
  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

  mem_wb_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            halted_q, halted_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [31:0]     rf_wdata_q, rf_wdata_d;
  logic [4:0]      ld_waddr_q, ld_waddr_d;
  logic [31:0]     ld_data_q, ld_data_d;

  instr_type_e     itype;
  logic            accept, live;
  logic            is_load, is_store, is_halt;
  logic [4:0]      dest;
  logic [31:0]     rd_data;
  logic [Aw-1:0]   mem_addr;

  logic unused_ex;
  assign unused_ex = ^{ex_aluout[31:Aw], ex_ir[31:21], ex_ir[10:0]};

  assign ex_ready = ~rst & ~halted_q & (state_q != StLoadWait);

  // A squashed instruction is still consumed, but as a bubble with no side effects.
  assign accept   = ex_valid & ex_ready;
  assign live     = accept & ~taken_branch;
  assign itype    = instr_type_e'(ex_type);
  assign is_load  = live & (itype == TypeLoad);
  assign is_store = live & (itype == TypeStore);
  assign is_halt  = live & (itype == TypeHalt);
  assign dest     = dest_reg(itype, ex_ir[15:11], ex_ir[20:16]);
  assign mem_addr = ex_aluout[Aw-1:0];

  mips_data_mem #(
    .Depth (MEM_DEPTH),
    .Aw    (Aw)
  ) u_data_mem (
    .clk_i      (clk1),
    .we_i       (is_store),
    .waddr_i    (mem_addr),
    .wdata_i    (ex_b),
    .raddr_i    (mem_addr),
    .rdata_o    (rd_data),
    .dbg_addr_i (Aw'(dbg_addr)),
    .dbg_data_o (dbg_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    halted_d   = halted_q | is_halt;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    ld_waddr_d = ld_waddr_q;
    ld_data_d  = ld_data_q;

    case (state_q)
      StLoadWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) begin
          state_d    = StWbLoad;
          rf_we_d    = (ld_waddr_q != 5'd0);
          rf_waddr_d = ld_waddr_q;
          rf_wdata_d = ld_data_q;
        end
      end
      default: begin
        state_d = StIdle;
        if (is_load && (MEM_LAT > 1)) begin
          // Nothing can be accepted while waiting, so the memory word cannot change
          // under us; capturing it now is equivalent to reading it at the end.
          state_d    = StLoadWait;
          cnt_d      = CntLoad;
          ld_waddr_d = dest;
          ld_data_d  = rd_data;
        end else if (live && (dest != 5'd0)) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = dest;
          rf_wdata_d = is_load ? rd_data : ex_aluout;
        end
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      ld_waddr_q <= '0;
      ld_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      ld_waddr_q <= ld_waddr_d;
      ld_data_q  <= ld_data_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign halted   = halted_q;

endmodule
